// File: rtl/mdio_pkg.sv
// Purpose : shared opcodes, field widths and FSM state type for the MDIO slave.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mdio_pkg;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;

   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ST2,
      S_OP,
      S_PHYAD,
      S_REGAD,
      S_TA,
      S_DATA
   } mdio_state_e;

endpackage

// File: rtl/mdio_slave_if.sv
// Purpose : pad-side MDIO levels plus the register-bank access bus.
// Latency : n/a (wiring only).
// Backpressure : none; the register bank must accept every strobe and return
//                read data exactly one clk after reg_rd.
// Signals : mdc_i/mdio_i pad levels in, mdio_o/mdio_oen pad drive out,
//           reg_addr/reg_wr/reg_wdata/reg_rd/reg_rdata bank access, frame_err.
interface mdio_slave_if;
   import mdio_pkg::*;

   logic                 mdc_i;
   logic                 mdio_i;
   logic                 mdio_o;
   logic                 mdio_oen;
   logic [REGAD_W-1:0]   reg_addr;
   logic                 reg_wr;
   logic [DATA_W-1:0]    reg_wdata;
   logic                 reg_rd;
   logic [DATA_W-1:0]    reg_rdata;
   logic                 frame_err;

   modport slave (
      input  mdc_i, mdio_i, reg_rdata,
      output mdio_o, mdio_oen, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err
   );

   modport master (
      output mdc_i, mdio_i, reg_rdata,
      input  mdio_o, mdio_oen, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err
   );

endinterface

// File: rtl/mdio_sync_edge.sv
// Purpose : SYNC_STAGES-deep synchroniser with a rising-edge detector.
// Latency : SYNC_STAGES clk to sync_o; rise_o is a 1-clk pulse on the synced 0->1.
// Backpressure : none.
// Ports : clk, rst_n, d_i (async level), sync_o (synced level), rise_o (edge pulse).
module mdio_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mdio_slave.sv
// Purpose : Clause-22 MDIO slave turning frames for PHY_ADDR into register-bank strobes.
// Latency : strobes/pad changes ~SYNC_STAGES+1 clk after the MDC rising edge at the pad.
// Backpressure : none; bank must return reg_rdata exactly 1 clk after reg_rd.
// Ports : clk, rst_n (async, active low), bus (mdio_slave_if.slave).
// Option : MDIO_PREAMBLE_SUPPRESS_EN defined -> one idle 1-bit suffices before ST.
module mdio_slave
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
   parameter int                 PREAMBLE_LEN = 32,
   parameter int                 SYNC_STAGES  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   mdio_slave_if.slave  bus
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam int PRE_REQ = 1;
`else
   localparam int PRE_REQ = PREAMBLE_LEN;
`endif
   localparam int             PCW     = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PCW-1:0] PRE_MAX = PCW'(PRE_REQ);

   logic mdc_rise, mdc_level_unused;
   logic mdio_s, mdio_rise_unused;

   mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mdc_sync (
      .clk(clk), .rst_n(rst_n), .d_i(bus.mdc_i), .sync_o(mdc_level_unused), .rise_o(mdc_rise)
   );

   mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mdio_sync (
      .clk(clk), .rst_n(rst_n), .d_i(bus.mdio_i), .sync_o(mdio_s), .rise_o(mdio_rise_unused)
   );

   mdio_state_e        state;
   logic [PCW-1:0]     pre_cnt;
   logic [3:0]         bit_cnt;
   logic               op_hi, is_rd, is_wr, match;
   logic [PHYAD_W-1:0] phyad;
   logic [REGAD_W-1:0] regad;
   logic [DATA_W-1:0]  wr_shift, rd_shift;
   logic               rd_d;

   logic               mdio_o_q, mdio_oen_q, reg_wr_q, reg_rd_q, frame_err_q;
   logic [REGAD_W-1:0] reg_addr_q;
   logic [DATA_W-1:0]  reg_wdata_q;

   // Field values including the bit being sampled on this mdc_rise.
   logic [REGAD_W-1:0] regad_nx;
   logic [DATA_W-1:0]  wr_nx;
   logic               rd_active;
   assign regad_nx  = {regad[REGAD_W-2:0], mdio_s};
   assign wr_nx     = {wr_shift[DATA_W-2:0], mdio_s};
   assign rd_active = is_rd & match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pre_cnt     <= '0;
         bit_cnt     <= '0;
         op_hi       <= 1'b0;
         is_rd       <= 1'b0;
         is_wr       <= 1'b0;
         match       <= 1'b0;
         phyad       <= '0;
         regad       <= '0;
         wr_shift    <= '0;
         rd_shift    <= '0;
         rd_d        <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_oen_q  <= 1'b1;
         reg_addr_q  <= '0;
         reg_wr_q    <= 1'b0;
         reg_wdata_q <= '0;
         reg_rd_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         frame_err_q <= 1'b0;
         // Bank answers one clk after the strobe; MDC is slow enough that no
         // mdc_rise can land on the capture cycle.
         rd_d        <= reg_rd_q;
         if (rd_d) rd_shift <= bus.reg_rdata;

         if (mdc_rise) begin
            case (state)
               S_IDLE: begin
                  if (mdio_s) begin
                     if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
                  end else if (pre_cnt == PRE_MAX) begin
                     state   <= S_ST2;
                     pre_cnt <= '0;
                  end else begin
                     pre_cnt <= '0;
                  end
               end
               S_ST2: begin
                  bit_cnt <= '0;
                  if (mdio_s) begin
                     state <= S_OP;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= S_IDLE;
                  end
               end
               S_OP: begin
                  if (bit_cnt == 4'd0) begin
                     op_hi   <= mdio_s;
                     bit_cnt <= 4'd1;
                  end else begin
                     bit_cnt <= '0;
                     is_rd   <= ({op_hi, mdio_s} == OP_RD);
                     is_wr   <= ({op_hi, mdio_s} == OP_WR);
                     if ({op_hi, mdio_s} == OP_RD || {op_hi, mdio_s} == OP_WR) begin
                        state <= S_PHYAD;
                     end else begin
                        frame_err_q <= 1'b1;
                        state       <= S_IDLE;
                     end
                  end
               end
               S_PHYAD: begin
                  phyad <= {phyad[PHYAD_W-2:0], mdio_s};
                  if (bit_cnt == 4'd4) begin
                     bit_cnt <= '0;
                     state   <= S_REGAD;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_REGAD: begin
                  regad <= regad_nx;
                  if (bit_cnt == 4'd4) begin
                     match   <= (phyad == PHY_ADDR);
                     bit_cnt <= '0;
                     state   <= S_TA;
                     if (is_rd && phyad == PHY_ADDR) begin
                        reg_addr_q <= regad_nx;
                        reg_rd_q   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_TA: begin
                  if (bit_cnt == 4'd0) begin
                     bit_cnt <= 4'd1;
                     if (rd_active) begin
                        mdio_oen_q <= 1'b0;
                        mdio_o_q   <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= '0;
                     state   <= S_DATA;
                     if (rd_active) begin
                        mdio_o_q <= rd_shift[DATA_W-1];
                        rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                     end
                  end
               end
               S_DATA: begin
                  wr_shift <= wr_nx;
                  if (bit_cnt == 4'd15) begin
                     bit_cnt <= '0;
                     pre_cnt <= '0;
                     state   <= S_IDLE;
                     if (rd_active) begin
                        mdio_oen_q <= 1'b1;
                        mdio_o_q   <= 1'b1;
                     end
                     if (is_wr && match) begin
                        reg_addr_q  <= regad;
                        reg_wdata_q <= wr_nx;
                        reg_wr_q    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (rd_active) begin
                        mdio_o_q <= rd_shift[DATA_W-1];
                        rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.mdio_o    = mdio_o_q;
   assign bus.mdio_oen  = mdio_oen_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wr    = reg_wr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_rd    = reg_rd_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Purpose : directed bench for mdio_slave acting as MDIO master plus register bank.
// Latency : MDC = 8 clk per bit; bank returns data exactly 1 clk after reg_rd.
// Backpressure : none.
module tb_mdio_slave;
   import mdio_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mdio_slave_if bus();

   mdio_slave #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Register bank: data is only valid in the single cycle after reg_rd.
   logic [15:0] bank_val = 16'h0000;
   always @(posedge clk) bus.reg_rdata <= (bus.reg_rd === 1'b1) ? bank_val : 16'hDEAD;

   int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oen_low_cnt = 0, both_cnt = 0;
   logic [4:0]  wr_addr = '0, rd_addr = '0;
   logic [15:0] wr_data = '0;
   always @(negedge clk) begin
      if (bus.reg_wr === 1'b1) begin
         wr_cnt++;
         wr_addr = bus.reg_addr;
         wr_data = bus.reg_wdata;
      end
      if (bus.reg_rd === 1'b1) begin
         rd_cnt++;
         rd_addr = bus.reg_addr;
      end
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.mdio_oen === 1'b0) oen_low_cnt++;
      if (bus.reg_wr === 1'b1 && bus.reg_rd === 1'b1) both_cnt++;
   end

   task automatic send_bit(input logic b);
      bus.mdio_i = b;
      bus.mdc_i  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.mdc_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Master releases the line and samples just before the MDC rise.
   task automatic sample_bit(output logic oen, output logic o);
      bus.mdio_i = 1'b1;
      bus.mdc_i  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      oen = bus.mdio_oen;
      o   = bus.mdio_o;
      bus.mdc_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic preamble(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(op[1]);
      send_bit(op[0]);
      for (int i = 4; i >= 0; i--) send_bit(phy[i]);
      for (int i = 4; i >= 0; i--) send_bit(rg[i]);
   endtask

   task automatic write_frame(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
      send_header(OP_WR, phy, rg);
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 15; i >= 0; i--) send_bit(d[i]);
      send_bit(1'b1);
   endtask

   task automatic read_frame(input logic [4:0] phy, input logic [4:0] rg,
                             output logic ta2_oen, output logic ta2_o, output logic [15:0] data,
                             output logic data_oen_ok, output logic oen_after);
      logic soe, so;
      send_header(OP_RD, phy, rg);
      send_bit(1'b1);
      sample_bit(soe, so);
      ta2_oen = soe;
      ta2_o = so;
      data_oen_ok = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         sample_bit(soe, so);
         data[i] = so;
         if (soe !== 1'b0) data_oen_ok = 1'b0;
      end
      sample_bit(soe, so);
      oen_after = soe;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.mdc_i = 1'b0;
      bus.mdio_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.mdc_i = 1'b0;
      bus.mdio_i = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.mdio_o !== 1'b1) begin n_bad++; $display("FAIL reset_mdio_o: got %b want 1", bus.mdio_o); end
      n_cmp++; if (bus.mdio_oen !== 1'b1) begin n_bad++; $display("FAIL reset_mdio_oen: got %b want 1", bus.mdio_oen); end
      n_cmp++; if (bus.reg_addr !== 5'd0) begin n_bad++; $display("FAIL reset_reg_addr: got %h want 00", bus.reg_addr); end
      n_cmp++; if (bus.reg_wr !== 1'b0) begin n_bad++; $display("FAIL reset_reg_wr: got %b want 0", bus.reg_wr); end
      n_cmp++; if (bus.reg_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_reg_wdata: got %h want 0000", bus.reg_wdata); end
      n_cmp++; if (bus.reg_rd !== 1'b0) begin n_bad++; $display("FAIL reset_reg_rd: got %b want 0", bus.reg_rd); end
      n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      int w0 = wr_cnt, r0 = rd_cnt, o0 = oen_low_cnt;
      preamble(32);
      write_frame(5'd1, 5'h03, 16'hA5C3);
      n_cmp++; if (wr_cnt - w0 != 1) begin n_bad++; $display("FAIL write_count: got %0d want 1", wr_cnt - w0); end
      n_cmp++; if (wr_addr !== 5'h03) begin n_bad++; $display("FAIL write_addr: got %h want 03", wr_addr); end
      n_cmp++; if (wr_data !== 16'hA5C3) begin n_bad++; $display("FAIL write_data: got %h want a5c3", wr_data); end
      n_cmp++; if (rd_cnt - r0 != 0) begin n_bad++; $display("FAIL write_no_rd: got %0d want 0", rd_cnt - r0); end
      n_cmp++; if (oen_low_cnt - o0 != 0) begin n_bad++; $display("FAIL write_oen_high: got %0d low cycles want 0", oen_low_cnt - o0); end
   endtask

   task automatic test_read();
      int w0 = wr_cnt, r0 = rd_cnt;
      logic ta2_oen, ta2_o, ok, oen_after;
      logic [15:0] d;
      bank_val = 16'h1234;
      preamble(32);
      read_frame(5'd1, 5'h1F, ta2_oen, ta2_o, d, ok, oen_after);
      n_cmp++; if (rd_cnt - r0 != 1) begin n_bad++; $display("FAIL read_count: got %0d want 1", rd_cnt - r0); end
      n_cmp++; if (rd_addr !== 5'h1F) begin n_bad++; $display("FAIL read_addr: got %h want 1f", rd_addr); end
      n_cmp++; if (ta2_oen !== 1'b0) begin n_bad++; $display("FAIL read_ta2_oen: got %b want 0", ta2_oen); end
      n_cmp++; if (ta2_o !== 1'b0) begin n_bad++; $display("FAIL read_ta2_val: got %b want 0", ta2_o); end
      n_cmp++; if (d !== 16'h1234) begin n_bad++; $display("FAIL read_data: got %h want 1234", d); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL read_data_oen: got %b want 1", ok); end
      n_cmp++; if (oen_after !== 1'b1) begin n_bad++; $display("FAIL read_oen_release: got %b want 1", oen_after); end
      n_cmp++; if (wr_cnt - w0 != 0) begin n_bad++; $display("FAIL read_no_wr: got %0d want 0", wr_cnt - w0); end
   endtask

   task automatic test_mismatch();
      int w0 = wr_cnt, r0 = rd_cnt, o0 = oen_low_cnt;
      logic ta2_oen, ta2_o, ok, oen_after;
      logic [15:0] d;
      bank_val = 16'hFFFF;
      preamble(32);
      read_frame(5'd2, 5'h1F, ta2_oen, ta2_o, d, ok, oen_after);
      n_cmp++; if (rd_cnt - r0 != 0) begin n_bad++; $display("FAIL mismatch_no_rd: got %0d want 0", rd_cnt - r0); end
      n_cmp++; if (wr_cnt - w0 != 0) begin n_bad++; $display("FAIL mismatch_no_wr: got %0d want 0", wr_cnt - w0); end
      n_cmp++; if (oen_low_cnt - o0 != 0) begin n_bad++; $display("FAIL mismatch_oen_high: got %0d low cycles want 0", oen_low_cnt - o0); end
      preamble(32);
      write_frame(5'd1, 5'h05, 16'h0F0F);
      n_cmp++; if (wr_cnt - w0 != 1) begin n_bad++; $display("FAIL mismatch_next_wr_count: got %0d want 1", wr_cnt - w0); end
      n_cmp++; if (wr_addr !== 5'h05) begin n_bad++; $display("FAIL mismatch_next_wr_addr: got %h want 05", wr_addr); end
      n_cmp++; if (wr_data !== 16'h0F0F) begin n_bad++; $display("FAIL mismatch_next_wr_data: got %h want 0f0f", wr_data); end
   endtask

   task automatic test_short_preamble();
      int w0, exp_wr;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      exp_wr = 1;
`else
      exp_wr = 0;
`endif
      do_reset();
      w0 = wr_cnt;
      preamble(31);
      write_frame(5'd1, 5'h07, 16'h5A5A);
      n_cmp++; if (wr_cnt - w0 != exp_wr) begin n_bad++; $display("FAIL short_preamble_wr: got %0d want %0d", wr_cnt - w0, exp_wr); end
   endtask

   task automatic test_bad_frame();
      int e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
      logic ta2_oen, ta2_o, ok, oen_after;
      logic [15:0] d;
      preamble(32);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL bad_st_err: got %0d want 1", err_cnt - e0); end
      preamble(32);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      n_cmp++; if (err_cnt - e0 != 2) begin n_bad++; $display("FAIL bad_op_err: got %0d want 2", err_cnt - e0); end
      n_cmp++; if (wr_cnt - w0 != 0 || rd_cnt - r0 != 0) begin n_bad++; $display("FAIL bad_no_strobe: got wr %0d rd %0d want 0 0", wr_cnt - w0, rd_cnt - r0); end
      bank_val = 16'hC0DE;
      preamble(32);
      read_frame(5'd1, 5'h0A, ta2_oen, ta2_o, d, ok, oen_after);
      n_cmp++; if (d !== 16'hC0DE) begin n_bad++; $display("FAIL bad_then_read_data: got %h want c0de", d); end
      n_cmp++; if (rd_cnt - r0 != 1) begin n_bad++; $display("FAIL bad_then_read_count: got %0d want 1", rd_cnt - r0); end
   endtask

   task automatic test_reset_mid_read();
      logic soe, so, oen_before;
      logic ta2_oen, ta2_o, ok, oen_after;
      logic [15:0] d;
      bank_val = 16'h1234;
      preamble(32);
      send_header(OP_RD, 5'd1, 5'h1F);
      send_bit(1'b1);
      sample_bit(soe, so);
      for (int i = 15; i >= 9; i--) sample_bit(soe, so);
      // Low phase of D8: slave is driving; pull reset here.
      bus.mdio_i = 1'b1;
      bus.mdc_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      oen_before = bus.mdio_oen;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (oen_before !== 1'b0) begin n_bad++; $display("FAIL midrd_driving: got %b want 0", oen_before); end
      n_cmp++; if (bus.mdio_oen !== 1'b1) begin n_bad++; $display("FAIL midrd_oen_async: got %b want 1", bus.mdio_oen); end
      n_cmp++; if (bus.mdio_o !== 1'b1) begin n_bad++; $display("FAIL midrd_o_async: got %b want 1", bus.mdio_o); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bank_val = 16'h8001;
      preamble(32);
      read_frame(5'd1, 5'h02, ta2_oen, ta2_o, d, ok, oen_after);
      n_cmp++; if (d !== 16'h8001) begin n_bad++; $display("FAIL midrd_fresh_data: got %h want 8001", d); end
      n_cmp++; if (rd_addr !== 5'h02) begin n_bad++; $display("FAIL midrd_fresh_addr: got %h want 02", rd_addr); end
      n_cmp++; if (oen_after !== 1'b1) begin n_bad++; $display("FAIL midrd_fresh_release: got %b want 1", oen_after); end
   endtask

   initial begin
      bus.mdc_i = 1'b0;
      bus.mdio_i = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_short_preamble();
      test_bad_frame();
      test_reset_mid_read();
      n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL wr_rd_overlap: got %0d cycles want 0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
